uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a ready/valid FIFO front end.
// Configurable data width, parity, stop bits and compile-time baud divisor.
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// START | start bit (low)
// DATA  | data bits, LSB first
// PAR   | parity bit (only when PARITY != 0)
// STOP  | stop bit(s), line high
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL      = FIFO_DEPTH[AW:0];
    localparam logic [15:0] LAST_TICK = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DB_LAST   = 4'(DATA_BITS - 1);
    localparam logic [3:0]  SB_LAST   = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count_q, count_d;
    state_t               state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, head;
    logic                 par_q, par_d, tx_q, tx_d;
    logic                 push, pop, tick, start_frame;

    assign head       = mem[rd_ptr];
    assign tx_ready   = (count_q != FULL);
    assign push       = tx_valid && tx_ready;
    assign tick       = (baud_q == LAST_TICK);
    assign tx_out     = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        par_d       = par_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) start_frame = 1'b1;
            end
            START: begin
                baud_d = baud_q + 16'd1;
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = DB_LAST;
                    state_d = DATA;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                baud_d = baud_q + 16'd1;
                if (tick) begin
                    baud_d = '0;
                    sh_d   = sh_q >> 1;
                    if (bit_q != '0) begin
                        bit_d = bit_q - 4'd1;
                        tx_d  = sh_q[1];
                    end else if (PARITY != 0) begin
                        state_d = PAR;
                        tx_d    = par_q;
                    end else begin
                        state_d = STOP;
                        bit_d   = SB_LAST;
                        tx_d    = 1'b1;
                    end
                end
            end
            PAR: begin
                baud_d = baud_q + 16'd1;
                if (tick) begin
                    baud_d  = '0;
                    state_d = STOP;
                    bit_d   = SB_LAST;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                baud_d = baud_q + 16'd1;
                if (tick) begin
                    baud_d = '0;
                    if (bit_q != '0)         bit_d = bit_q - 4'd1;
                    else if (count_q != '0) start_frame = 1'b1;
                    else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Pop and start share one edge, so back-to-back frames have no gap.
        if (start_frame) begin
            pop     = 1'b1;
            sh_d    = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
            state_d = START;
            baud_d  = '0;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations checked cycle by cycle against
// an ideal frame waveform computed from the word, width, parity and stop count.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v   [4];
    logic [8:0] d   [4];
    logic       rdy [4];
    logic       tx  [4];
    logic       bsy [4];
    logic [2:0] cnt [4];

    int checks = 0;
    int failures = 0;
    logic [8:0] words [$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
        .clk(clk), .reset(reset), .tx_valid(v[0]), .tx_data(d[0][7:0]), .tx_ready(rdy[0]),
        .tx_out(tx[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) d1 (
        .clk(clk), .reset(reset), .tx_valid(v[1]), .tx_data(d[1][6:0]), .tx_ready(rdy[1]),
        .tx_out(tx[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
        .clk(clk), .reset(reset), .tx_valid(v[2]), .tx_data(d[2][6:0]), .tx_ready(rdy[2]),
        .tx_out(tx[2]), .busy(bsy[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_DIV(434), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d3 (
        .clk(clk), .reset(reset), .tx_valid(v[3]), .tx_data(d[3][7:0]), .tx_ready(rdy[3]),
        .tx_out(tx[3]), .busy(bsy[3]), .fifo_count(cnt[3]));

    function automatic int div_of(input int s); return (s == 3) ? 434 : 4; endfunction
    function automatic int nb_of(input int s);  return (s == 1 || s == 2) ? 7 : 8; endfunction
    function automatic int par_of(input int s); return (s == 1) ? 1 : (s == 2) ? 2 : 0; endfunction
    function automatic int st_of(input int s);  return (s == 1) ? 2 : 1; endfunction

    function automatic int flen(input int s);
        return (1 + nb_of(s) + ((par_of(s) != 0) ? 1 : 0) + st_of(s)) * div_of(s);
    endfunction

    // Ideal line level c cycles after the start bit began.
    function automatic logic frame_level(input int s, input logic [8:0] word, input int c);
        int idx, nb, ones;
        logic [8:0] mask;
        nb   = nb_of(s);
        idx  = c / div_of(s);
        mask = 9'((1 << nb) - 1);
        ones = $countones(word & mask);
        if (idx == 0) return 1'b0;
        if (idx <= nb) return word[idx-1];
        if (par_of(s) != 0 && idx == nb + 1)
            return (par_of(s) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the first pop edge. words[0] is on the
    // line, m0 words are queued. Pushes random words at cycles < npush and at
    // cycle xpush, tracking FIFO occupancy from push/pop counts alone.
    task automatic stream(input int s, input int npush, input int xpush, input int m0);
        int c = 0;
        int m = m0;
        int fl = flen(s);
        int push, pop;
        logic [8:0] w;
        while (c < fl * words.size() && c < 20000) begin
            chk($sformatf("tx s%0d c%0d", s, c), tx[s], frame_level(s, words[c / fl], c % fl));
            chk($sformatf("busy s%0d c%0d", s, c), bsy[s], 1);
            chk($sformatf("count s%0d c%0d", s, c), cnt[s], m);
            chk($sformatf("ready s%0d c%0d", s, c), rdy[s], m != 4);
            pop = ((c % fl) == fl - 1 && m > 0) ? 1 : 0;
            push = 0;
            if (c < npush || c == xpush) begin
                w = 9'($urandom_range(0, (1 << nb_of(s)) - 1));
                v[s] = 1'b1;
                d[s] = w;
                if (m != 4) begin
                    push = 1;
                    words.push_back(w);
                end
            end else begin
                v[s] = 1'b0;
            end
            m = m + push - pop;
            c++;
            @(negedge clk);
        end
        v[s] = 1'b0;
        chk($sformatf("end_tx s%0d", s), tx[s], 1);
        chk($sformatf("end_busy s%0d", s), bsy[s], 0);
        chk($sformatf("end_count s%0d", s), cnt[s], 0);
    endtask

    task automatic send_one(input int s, input logic [8:0] w);
        words.delete();
        words.push_back(w);
        v[s] = 1'b1;
        d[s] = w;
        @(negedge clk);
        v[s] = 1'b0;
        chk($sformatf("queued_count s%0d", s), cnt[s], 1);
        chk($sformatf("pre_start_tx s%0d", s), tx[s], 1);
        @(negedge clk);
        stream(s, 0, -1, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tx s%0d", i), tx[i], 1);
            chk($sformatf("rst_ready s%0d", i), rdy[i], 1);
            chk($sformatf("rst_busy s%0d", i), bsy[i], 0);
            chk($sformatf("rst_count s%0d", i), cnt[i], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // 8N1 single frame, fixed word
        send_one(0, 9'h0A5);

        // Parity and two stop bits, fixed then random words
        send_one(1, 9'h003);
        send_one(2, 9'h003);
        send_one(1, 9'($urandom_range(0, 127)));
        send_one(2, 9'($urandom_range(0, 127)));

        // Queueing: six pushes at one per cycle; the first is popped the edge
        // after it lands, so five fit and the sixth meets a full FIFO.
        words.delete();
        words.push_back(9'($urandom_range(0, 255)));
        v[0] = 1'b1;
        d[0] = words[0];
        @(negedge clk);
        chk("q_count_first", cnt[0], 1);
        words.push_back(9'($urandom_range(0, 255)));
        d[0] = words[1];
        @(negedge clk);
        stream(0, 4, -1, 1);

        // Push on the exact edge the last queued word is popped
        words.delete();
        words.push_back(9'($urandom_range(0, 255)));
        v[0] = 1'b1;
        d[0] = words[0];
        @(negedge clk);
        words.push_back(9'($urandom_range(0, 255)));
        d[0] = words[1];
        @(negedge clk);
        stream(0, 0, 39, 1);

        // Reset during data bit 3 (cycles 16..19 of the frame)
        words.delete();
        words.push_back(9'h0F0);
        v[0] = 1'b1;
        d[0] = 9'h0F0;
        @(negedge clk);
        d[0] = 9'($urandom_range(0, 255));
        @(negedge clk);
        v[0] = 1'b0;
        for (int c = 0; c < 17; c++) begin
            chk($sformatf("pre_rst_tx c%0d", c), tx[0], frame_level(0, 9'h0F0, c));
            @(negedge clk);
        end
        chk("pre_rst_bit3", tx[0], 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", tx[0], 1);
        chk("mid_rst_count", cnt[0], 0);
        chk("mid_rst_busy", bsy[0], 0);
        chk("mid_rst_ready", rdy[0], 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("post_rst_idle_tx c%0d", c), tx[0], 1);
            chk($sformatf("post_rst_idle_busy c%0d", c), bsy[0], 0);
            @(negedge clk);
        end
        send_one(0, 9'($urandom_range(0, 255)));

        // Full-rate divisor: every bit of a 0x55 frame held 434 cycles
        send_one(3, 9'h055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
